// File: rtl/rx_fifo_if.sv
// Router input port bundle: two-phase flit channel, switch side, routing table and status.
interface rx_fifo_if #(
  parameter int SIZE      = 8,
  parameter int PORT_BITS = 8
);
  logic                 ch_req;
  logic [SIZE-1:0]      ch_flit;
  logic                 ch_ack;
  logic                 sw_req;
  logic [PORT_BITS-1:0] sw_chnl;
  logic                 sw_gnt;
  logic                 buf_pop;
  logic [SIZE-1:0]      buf_data;
  logic [SIZE-2:0]      table_addr;
  logic [PORT_BITS-1:0] table_data;
  logic [15:0]          pkt_count;
  logic                 err;

  modport slave (
    input  ch_req, ch_flit, sw_gnt, buf_pop, table_data,
    output ch_ack, sw_req, sw_chnl, buf_data, table_addr, pkt_count, err
  );

  modport master (
    output ch_req, ch_flit, sw_gnt, buf_pop, table_data,
    input  ch_ack, sw_req, sw_chnl, buf_data, table_addr, pkt_count, err
  );
endinterface

// File: rtl/rx_fifo.sv
// Router input port: receives flits on a two-phase channel, routes heads, buffers them in a
// circular FIFO and forwards whole packets to the switch (or counts and drops them in sink mode).
module rx_fifo #(
  parameter int ID           = 0,
  parameter int SUBID        = 0,
  parameter int SIZE         = 8,
  parameter int BUFF_BITS    = 4,
  parameter int PKT_FLITS    = 8,
  parameter int PORT_BITS    = 8,
  parameter int SINK_PACKETS = 0
) (
  input logic      clk,
  input logic      reset,
  rx_fifo_if.slave bus
);
  localparam int FLITS = 2**BUFF_BITS;
  localparam int CW    = $clog2(PKT_FLITS + 1);
  localparam logic [BUFF_BITS:0] FULL     = (BUFF_BITS+1)'(FLITS);
  localparam logic [CW-1:0]      PKT_N    = CW'(PKT_FLITS);
  localparam logic [CW-1:0]      PKT_LAST = CW'(PKT_FLITS - 1);
  localparam bit                 SINK     = (SINK_PACKETS != 0);

  if (PKT_FLITS < 2 || PKT_FLITS > FLITS) begin : g_bad_pkt
    $error("rx_fifo %0d.%0d: PKT_FLITS out of range", ID, SUBID);
  end

  typedef enum logic [1:0] {RX_IDLE, RX_LATCHED, RX_RC, RX_BUF} rx_state_e;
  typedef enum logic [1:0] {FW_IDLE, FW_REQ, FW_SEND} fw_state_e;

  rx_state_e            rx_q, rx_d;
  fw_state_e            fw_q, fw_d;
  logic                 ch_req_old_q;
  logic [SIZE-1:0]      flit_q, flit_d;
  logic                 ch_ack_q, ch_ack_d;
  logic [SIZE-2:0]      table_addr_q, table_addr_d;
  logic [CW-1:0]        flit_cnt_q, flit_cnt_d;
  logic [CW-1:0]        popped_q, popped_d;
  logic [BUFF_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUFF_BITS:0]   count_q;
  logic [PORT_BITS-1:0] pq_q [2];
  logic                 pq_wr_q, pq_rd_q;
  logic [1:0]           pq_cnt_q;
  logic [1:0]           ready_cnt_q;
  logic                 sw_req_q, sw_req_d;
  logic [PORT_BITS-1:0] sw_chnl_q, sw_chnl_d;
  logic [15:0]          pkt_count_q;
  logic                 err_q;
  logic [SIZE-1:0]      mem_q [FLITS];

  logic                 req;
  logic                 fifo_push, pkt_rx_done, pq_push, pq_pop, fw_done, rx_err, fw_err;
  logic [BUFF_BITS:0]   pop_amt;

  assign req    = bus.ch_req ^ ch_req_old_q;
  assign pq_pop = SINK ? pkt_rx_done : fw_done;

  always_comb begin
    rx_d         = rx_q;
    flit_d       = flit_q;
    ch_ack_d     = ch_ack_q;
    table_addr_d = table_addr_q;
    flit_cnt_d   = flit_cnt_q;
    fifo_push    = 1'b0;
    pkt_rx_done  = 1'b0;
    pq_push      = 1'b0;
    rx_err       = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        if (req) begin
          flit_d = bus.ch_flit;
          rx_d   = RX_LATCHED;
        end
      end
      RX_LATCHED: begin
        if (flit_cnt_q == '0 && flit_q[SIZE-1]) begin
          if (pq_cnt_q != 2'd2) begin
            table_addr_d = flit_q[SIZE-2:0];
            rx_d         = RX_RC;
          end
        end else if (flit_cnt_q == '0 || flit_q[SIZE-1]) begin
          // Misplaced head or orphan body: acknowledge and drop, packet in progress is kept.
          rx_err   = 1'b1;
          ch_ack_d = ~ch_ack_q;
          rx_d     = RX_IDLE;
        end else begin
          rx_d = RX_BUF;
        end
      end
      RX_RC: begin
        pq_push = 1'b1;
        rx_d    = RX_BUF;
      end
      RX_BUF: begin
        if (count_q != FULL) begin
          fifo_push = !SINK;
          ch_ack_d  = ~ch_ack_q;
          rx_d      = RX_IDLE;
          if (flit_cnt_q == PKT_LAST) begin
            flit_cnt_d  = '0;
            pkt_rx_done = 1'b1;
          end else begin
            flit_cnt_d = flit_cnt_q + 1'b1;
          end
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  always_comb begin
    fw_d      = fw_q;
    sw_req_d  = sw_req_q;
    sw_chnl_d = sw_chnl_q;
    popped_d  = popped_q;
    pop_amt   = '0;
    fw_done   = 1'b0;
    fw_err    = 1'b0;
    unique case (fw_q)
      FW_IDLE: begin
        if (!SINK && ready_cnt_q != 2'd0) begin
          sw_req_d  = 1'b1;
          sw_chnl_d = pq_q[pq_rd_q];
          fw_d      = FW_REQ;
        end
      end
      FW_REQ: begin
        if (bus.sw_gnt) begin
          sw_req_d = 1'b0;
          popped_d = '0;
          fw_d     = FW_SEND;
        end
      end
      FW_SEND: begin
        if (bus.sw_gnt) begin
          // Pops beyond the packet length would eat into the next packet.
          if (bus.buf_pop && count_q != '0 && popped_q != PKT_N) begin
            pop_amt  = (BUFF_BITS+1)'(1);
            popped_d = popped_q + 1'b1;
          end
        end else begin
          pop_amt  = (BUFF_BITS+1)'(PKT_N - popped_q);
          fw_err   = (popped_q != PKT_N);
          fw_done  = 1'b1;
          popped_d = '0;
          fw_d     = FW_IDLE;
        end
      end
      default: fw_d = FW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q         <= RX_IDLE;
      fw_q         <= FW_IDLE;
      ch_req_old_q <= 1'b0;
      flit_q       <= '0;
      ch_ack_q     <= 1'b0;
      table_addr_q <= '0;
      flit_cnt_q   <= '0;
      popped_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pq_q[0]      <= '0;
      pq_q[1]      <= '0;
      pq_wr_q      <= 1'b0;
      pq_rd_q      <= 1'b0;
      pq_cnt_q     <= '0;
      ready_cnt_q  <= '0;
      sw_req_q     <= 1'b0;
      sw_chnl_q    <= '0;
      pkt_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rx_q         <= rx_d;
      fw_q         <= fw_d;
      ch_req_old_q <= bus.ch_req;
      flit_q       <= flit_d;
      ch_ack_q     <= ch_ack_d;
      table_addr_q <= table_addr_d;
      flit_cnt_q   <= flit_cnt_d;
      popped_q     <= popped_d;
      sw_req_q     <= sw_req_d;
      sw_chnl_q    <= sw_chnl_d;
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_q + pop_amt[BUFF_BITS-1:0];
      count_q  <= count_q + (BUFF_BITS+1)'(fifo_push) - pop_amt;
      if (pq_push) begin
        pq_q[pq_wr_q] <= bus.table_data;
        pq_wr_q       <= ~pq_wr_q;
      end
      if (pq_pop) begin
        pq_rd_q     <= ~pq_rd_q;
        pkt_count_q <= pkt_count_q + 1'b1;
      end
      pq_cnt_q    <= pq_cnt_q + 2'(pq_push) - 2'(pq_pop);
      ready_cnt_q <= ready_cnt_q + 2'(pkt_rx_done && !SINK) - 2'(fw_done);
      if (rx_err || fw_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= flit_q;
  end

  assign bus.ch_ack     = ch_ack_q;
  assign bus.sw_req     = sw_req_q;
  assign bus.sw_chnl    = sw_chnl_q;
  assign bus.buf_data   = mem_q[rd_ptr_q];
  assign bus.table_addr = table_addr_q;
  assign bus.pkt_count  = pkt_count_q;
  assign bus.err        = err_q;
endmodule
